// File: rtl/definitions_pkg.sv
// Shared UART definitions: parity selection type and default line-rate constants.
package definitions_pkg;

   localparam int unsigned CLOCK_RATE = 50_000_000;
   localparam int unsigned BAUD_RATE  = 115_200;

   // 2'b11 is deliberately left unnamed; the transmitter treats it as no parity.
   typedef enum logic [1:0] {
      PARITY_NONE = 2'b00,
      PARITY_EVEN = 2'b01,
      PARITY_ODD  = 2'b10
   } parity_e;

   // True only for the two encodings that add a parity bit to the frame.
   function automatic logic parity_enabled(input parity_e mode);
      return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while running and strobes
// bit_end in the last cycle of each bit. A synchronous restart zeroes the
// phase so every frame begins on a fresh bit boundary.
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic run,
   output logic bit_end
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign bit_end = run && (cnt_q == LAST);

   // Next count: restart and idle hold zero, otherwise wrap at the bit end.
   always_comb begin
      cnt_d = cnt_q;
      if (restart || !run) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// parity bit, one or two stop bits. Frame configuration is captured at
// acceptance; ready is offered in the final stop-bit cycle so frames can
// be sent back to back with no idle gap.
module uart_transmitter
   import definitions_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enabled,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic [DATA_BITS-1:0] tx_data,
   input  parity_e              parity_mode,
   input  logic                 two_stop,
   output logic                 busy,
   output logic                 done,
   output logic                 out
);

   localparam int BCW = $clog2(DATA_BITS);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]           state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic                 par_en_q, par_en_d;
   logic                 par_bit_q, par_bit_d;
   logic                 two_stop_q, two_stop_d;
   logic                 ready_en_q;

   logic bit_end;
   logic accept;
   logic last_stop;

   // ready_en_q keeps tx_ready low through reset and rises on the first edge after it.
   assign last_stop = (state_q == S_STOP) && bit_end && (!two_stop_q || stop_cnt_q);
   assign done      = enabled && last_stop;
   assign tx_ready  = ready_en_q && enabled && ((state_q == S_IDLE) || last_stop);
   assign accept    = tx_valid && tx_ready;
   assign busy      = (state_q != S_IDLE);

   baud_tick_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .restart(accept),
      .run    (busy),
      .bit_end(bit_end)
   );

   // Serial line value for the bit currently being sent; idle and stop are high.
   always_comb begin
      out = 1'b1;
      case (state_q)
         S_START:  out = 1'b0;
         S_DATA:   out = shift_q[0];
         S_PARITY: out = par_bit_q;
         default:  out = 1'b1;
      endcase
   end

   // Frame sequencing: abort on disable, load on accept, advance on bit end.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      two_stop_d = two_stop_q;
      if (!enabled) begin
         state_d    = S_IDLE;
         shift_d    = '0;
         bit_cnt_d  = '0;
         stop_cnt_d = 1'b0;
      end else if (accept) begin
         state_d    = S_START;
         shift_d    = tx_data;
         bit_cnt_d  = '0;
         stop_cnt_d = 1'b0;
         par_en_d   = parity_enabled(parity_mode);
         par_bit_d  = (^tx_data) ^ (parity_mode == PARITY_ODD);
         two_stop_d = two_stop;
      end else if (bit_end) begin
         case (state_q)
            S_START: state_d = S_DATA;
            S_DATA: begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            S_PARITY: state_d = S_STOP;
            S_STOP: begin
               if (two_stop_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  stop_cnt_d = 1'b0;
                  state_d    = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers; reset aborts any frame immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         two_stop_q <= two_stop_d;
         ready_en_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: table of frame configurations plus hand
// sequences for back-to-back, abort, mid-frame reset and a 7-bit instance.
module tb_uart_transmitter;
   import definitions_pkg::*;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enabled = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   parity_e    parity_mode = PARITY_NONE;
   logic       two_stop = 1'b0;
   logic       tx_ready, busy, done, out;

   logic       enabled7 = 1'b0;
   logic       tx_valid7 = 1'b0;
   logic [6:0] tx_data7 = 7'h00;
   parity_e    parity_mode7 = PARITY_NONE;
   logic       two_stop7 = 1'b0;
   logic       tx_ready7, busy7, done7, out7;

   uart_transmitter #(.DATA_BITS(8), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .enabled(enabled), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_data(tx_data), .parity_mode(parity_mode),
      .two_stop(two_stop), .busy(busy), .done(done), .out(out)
   );

   uart_transmitter #(.DATA_BITS(7), .CLKS_PER_BIT(CPB)) dut7 (
      .clk(clk), .rst(rst), .enabled(enabled7), .tx_valid(tx_valid7),
      .tx_ready(tx_ready7), .tx_data(tx_data7), .parity_mode(parity_mode7),
      .two_stop(two_stop7), .busy(busy7), .done(done7), .out(out7)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] wave;
      int          len;
      logic        aborted;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      parity_e    pm;
      logic       two;
      logic       has_par;
      logic       par;
      int         len;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[7];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   logic [63:0] cap = '0;

   // Expected per-cycle line waveform: bit i of the result is out in cycle i+1.
   function automatic logic [63:0] mk_wave(input logic [7:0] d, input int nb,
                                           input logic hp, input logic p, input logic two);
      logic [15:0] bits;
      logic [63:0] w;
      int n;
      bits = '0;
      bits[0] = 1'b0;
      n = 1;
      for (int i = 0; i < nb; i++) begin
         bits[n] = d[i];
         n = n + 1;
      end
      if (hp) begin
         bits[n] = p;
         n = n + 1;
      end
      bits[n] = 1'b1;
      n = n + 1;
      if (two) begin
         bits[n] = 1'b1;
         n = n + 1;
      end
      w = '0;
      for (int i = 0; i < n * CPB; i++) w[i] = bits[i / CPB];
      return w;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic end_frame(input logic ab);
      exp_t e;
      logic [63:0] mask;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_underflow actual=%0d cycles required=queued frame", cyc);
      end else begin
         e = sb.pop_front();
         mask = (e.len >= 64) ? '1 : ((64'd1 << e.len) - 64'd1);
         check("frame_len", 64'(cyc), 64'(e.len));
         check("frame_aborted", {63'd0, ab}, {63'd0, e.aborted});
         check("frame_wave", cap & mask, e.wave & mask);
      end
      cyc = 0;
      cap = '0;
   endtask

   // Monitor: a frame ends on done (complete) or on busy falling without done (aborted).
   initial begin
      forever begin
         @(negedge clk);
         if (busy) begin
            if (cyc < 64) cap[cyc] = out;
            cyc++;
            if (done) end_frame(1'b0);
         end else if (cyc > 0) begin
            end_frame(1'b1);
         end
      end
   end

   // Accept one word, push its expectation, then scramble the inputs.
   task automatic send(input logic [7:0] d, input parity_e pm, input logic two, input exp_t e);
      int t;
      @(negedge clk);
      tx_data = d;
      parity_mode = pm;
      two_stop = two;
      tx_valid = 1'b1;
      t = 0;
      while (!tx_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!tx_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=no ready required=ready within 200 cycles");
         tx_valid = 1'b0;
         return;
      end
      @(posedge clk);
      sb.push_back(e);
      #1;
      tx_valid = 1'b0;
      tx_data = ~d;
      parity_mode = (pm == PARITY_NONE) ? PARITY_ODD : PARITY_NONE;
      two_stop = ~two;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((sb.size() != 0 || busy) && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0 || busy) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      end
   endtask

   initial begin
      exp_t e;
      int t;
      logic [7:0] d8;
      logic [63:0] cap7, done7_seen;

      tbl[0] = '{8'h55, PARITY_NONE,      1'b0, 1'b0, 1'b0, 40};
      tbl[1] = '{8'h07, PARITY_EVEN,      1'b0, 1'b1, 1'b1, 44};
      tbl[2] = '{8'h00, PARITY_ODD,       1'b0, 1'b1, 1'b1, 44};
      tbl[3] = '{8'hA3, PARITY_EVEN,      1'b1, 1'b1, 1'b0, 48};
      tbl[4] = '{8'h3C, PARITY_ODD,       1'b1, 1'b1, 1'b1, 48};
      tbl[5] = '{8'h81, parity_e'(2'b11), 1'b0, 1'b0, 1'b0, 40};
      tbl[6] = '{8'hFF, PARITY_NONE,      1'b1, 1'b0, 1'b0, 44};

      // Reset state, with enabled high so tx_ready must be held low by reset.
      rst = 1'b1;
      enabled = 1'b1;
      enabled7 = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out", {63'd0, out}, 64'd1);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_ready", {63'd0, tx_ready}, 64'd0);
      rst = 1'b0;
      #1;
      check("ready_before_edge", {63'd0, tx_ready}, 64'd0);
      @(posedge clk);
      #1;
      check("ready_after_edge", {63'd0, tx_ready}, 64'd1);

      // Table-driven frames.
      for (int i = 0; i < 7; i++) begin
         e.wave = mk_wave(tbl[i].data, 8, tbl[i].has_par, tbl[i].par, tbl[i].two);
         e.len = tbl[i].len;
         e.aborted = 1'b0;
         send(tbl[i].data, tbl[i].pm, tbl[i].two, e);
         wait_drain();
      end

      // Back-to-back: 0xA5 then 0x3C with tx_valid held high.
      @(negedge clk);
      tx_data = 8'hA5;
      parity_mode = PARITY_NONE;
      two_stop = 1'b0;
      tx_valid = 1'b1;
      @(posedge clk);
      e.wave = mk_wave(8'hA5, 8, 1'b0, 1'b0, 1'b0);
      e.len = 40;
      e.aborted = 1'b0;
      sb.push_back(e);
      #1;
      tx_data = 8'h3C;
      t = 0;
      @(negedge clk);
      while (!tx_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("b2b_done_with_ready", {62'd0, done, tx_ready}, 64'd3);
      @(posedge clk);
      e.wave = mk_wave(8'h3C, 8, 1'b0, 1'b0, 1'b0);
      sb.push_back(e);
      #1;
      tx_valid = 1'b0;
      @(negedge clk);
      check("b2b_no_gap", {62'd0, busy, out}, 64'd2);
      wait_drain();

      // Abort: enabled dropped during cycle 13 of an 8N1 frame.
      e.wave = mk_wave(8'h55, 8, 1'b0, 1'b0, 1'b0);
      e.len = 13;
      e.aborted = 1'b1;
      send(8'h55, PARITY_NONE, 1'b0, e);
      repeat (12) @(posedge clk);
      #1;
      enabled = 1'b0;
      @(posedge clk);
      #1;
      check("abort_out", {63'd0, out}, 64'd1);
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_done", {63'd0, done}, 64'd0);
      check("disabled_ready", {63'd0, tx_ready}, 64'd0);
      @(negedge clk);
      enabled = 1'b1;
      e.wave = mk_wave(8'h96, 8, 1'b0, 1'b0, 1'b0);
      e.len = 40;
      e.aborted = 1'b0;
      send(8'h96, PARITY_NONE, 1'b0, e);
      wait_drain();

      // Reset pulsed during cycle 20 of an 8E2 frame.
      e.wave = mk_wave(8'hC3, 8, 1'b1, 1'b0, 1'b1);
      e.len = 19;
      e.aborted = 1'b1;
      send(8'hC3, PARITY_EVEN, 1'b1, e);
      repeat (19) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_out", {63'd0, out}, 64'd1);
      check("midrst_busy_done_ready", {61'd0, busy, done, tx_ready}, 64'd0);
      repeat (2) @(negedge clk);
      check("midrst_hold_ready", {63'd0, tx_ready}, 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_ready", {63'd0, tx_ready}, 64'd1);
      e.wave = mk_wave(8'h5A, 8, 1'b1, 1'b1, 1'b0);
      e.len = 44;
      e.aborted = 1'b0;
      send(8'h5A, PARITY_ODD, 1'b0, e);
      wait_drain();

      // 7N1 on the 7-bit instance; the top bit of the 8-bit source is dropped.
      d8 = 8'hFF;
      @(negedge clk);
      tx_data7 = d8[6:0];
      tx_valid7 = 1'b1;
      t = 0;
      while (!tx_ready7 && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("dbits7_ready", {63'd0, tx_ready7}, 64'd1);
      @(posedge clk);
      #1;
      tx_valid7 = 1'b0;
      tx_data7 = 7'h00;
      cap7 = '0;
      done7_seen = '0;
      for (int c = 0; c < 36; c++) begin
         @(negedge clk);
         cap7[c] = out7;
         done7_seen[c] = done7;
      end
      check("dbits7_wave", cap7, 64'h0000_000F_FFFF_FFF0);
      check("dbits7_done", done7_seen, 64'd1 << 35);
      @(negedge clk);
      check("dbits7_idle", {63'd0, busy7}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal values 5..9.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default CLOCK_RATE/BAUD_RATE, meaning clk cycles per serial bit; legal minimum 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port enabled, input, 1 bit: transmitter enable.
REQ-006 Port tx_valid, input, 1 bit: tx_data holds a word to send.
REQ-007 Port tx_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 Port tx_data, input, DATA_BITS bits: word to send, LSB first.
REQ-009 Port parity_mode, input, parity_e (2 bits): NONE, EVEN or ODD.
REQ-010 Port two_stop, input, 1 bit: 1 selects two stop bits, 0 selects one.
REQ-011 Port busy, output, 1 bit: a frame is in progress.
REQ-012 Port done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-013 Port out, output, 1 bit: serial line, idle high.

Function
REQ-014 Handshake: a word SHALL be accepted on any rising clk edge where tx_valid, tx_ready and enabled are all 1.
REQ-015 On acceptance the block SHALL latch tx_data, parity_mode and two_stop; later changes to these inputs SHALL NOT affect the frame in progress.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-017 Transitions SHALL be: IDLE to START on acceptance; START to DATA; DATA to PARITY after DATA_BITS bits when parity is not NONE, otherwise DATA to STOP; PARITY to STOP; STOP to IDLE after one or two stop bits.
REQ-018 Each bit (start, data, parity, stop) SHALL drive out for exactly CLKS_PER_BIT cycles, starting the cycle after acceptance.
REQ-019 The bit-timing counter SHALL restart at acceptance, so there is no residual phase from the previous frame; no derived or gated clocks are allowed.
REQ-020 Bit values: start = 0; data = latched word, LSB first; EVEN parity = XOR of the data bits; ODD parity = its inverse; stop = 1.
REQ-021 Frame length SHALL be CLKS_PER_BIT*(1+DATA_BITS+P+S) cycles, where P = 1 if parity is enabled, else 0, and S = 2 if two_stop, else 1.
REQ-022 tx_ready SHALL be 1 in IDLE when enabled = 1, and also in the final cycle of the final stop bit, so back-to-back frames have zero idle gap.
REQ-023 done SHALL pulse high for exactly one cycle: the final cycle of the final stop bit, coincident with that tx_ready.
REQ-024 busy SHALL be 1 from the cycle after acceptance until the last stop-bit cycle inclusive, and 0 in IDLE.
REQ-025 enabled = 0 mid-frame SHALL abort within one cycle: state goes to IDLE, out = 1, busy = 0, done = 0, and the word is discarded.
REQ-026 While enabled = 0, tx_ready SHALL be 0.
REQ-027 Illegal parity_mode encoding 2'b11 SHALL be treated as NONE.

Reset
REQ-028 While rst = 1, the block SHALL be in IDLE with out = 1, busy = 0, done = 0, tx_ready = 0, and all counters and shift registers at 0.
REQ-029 rst asserted mid-frame SHALL abort the frame immediately (asynchronously), with no done pulse.
REQ-030 After rst is released, tx_ready SHALL rise on the first clk edge if enabled = 1.

Structure
REQ-031 Typedef parity_e and constants CLOCK_RATE and BAUD_RATE SHALL live in definitions_pkg.
REQ-032 Bit timing SHALL be a sub-module baud_tick_gen (counter 0..CLKS_PER_BIT-1 with synchronous restart), emitting a one-cycle bit-end strobe.
REQ-033 Counter widths SHALL be derived with $clog2 from the parameters; no hard-coded widths.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-034 8N1 frame: send 0x55 -> out = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; 40 cycles total; done pulses in cycle 40.
REQ-035 Parity frames: 8E1 with 0x07 -> parity bit 1; 8O1 with 0x00 -> parity bit 1; 8E2 frame = 48 cycles.
REQ-036 DATA_BITS=7, 7N1: send 0x7F -> out = 0 then seven 1s then stop, 36 cycles total; upper tx_data bit ignored.
REQ-037 Back-to-back: tx_valid held high with 0xA5 then 0x3C -> second start bit begins in the cycle immediately after the first frame's done; no high gap.
REQ-038 Abort: enabled dropped at cycle 13 of an 8N1 frame -> out = 1 and busy = 0 by cycle 14, no done pulse; the next frame after re-enable is correct.
REQ-039 Reset mid-frame: rst pulsed at cycle 20 -> out = 1 asynchronously; all outputs at their reset values; config changes mid-frame do not alter the frame.
